// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding unit: tracks the destination tags of in-flight instructions,
// picks the youngest matching result for each ID source operand and flags load-use stalls.
module fwd_scoreboard_unit #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [NUM_SRC*XLEN-1:0]   rf_data,
    input  logic                      id_regwrite,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [1:0]                id_memtoreg,
    input  logic                      pipe_hold,
    input  logic                      flush,
    input  logic [DEPTH*XLEN-1:0]     stage_alu,
    input  logic [DEPTH*XLEN-1:0]     stage_rdata,
    input  logic [DEPTH*XLEN-1:0]     stage_pcn,
    output logic [NUM_SRC*XLEN-1:0]   fwd_data,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  v_r;
    logic [REG_AW-1:0] rd_r  [DEPTH];
    logic [1:0]        sel_r [DEPTH];
    logic [CNT_W-1:0]  cnt_r;
    logic [NUM_SRC-1:0] haz_s;
    logic              stall_s;

    // Operand selection: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = {NUM_SRC{1'b0}};
        haz_s    = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            logic             found;
            logic [IDX_W-1:0] win;
            logic             m;
            logic [1:0]       sel;
            found = 1'b0;
            win   = {IDX_W{1'b0}};
            for (int k = DEPTH - 1; k >= 0; k--) begin
                m = id_rs_used[i]
                    && (id_rs[i*REG_AW +: REG_AW] != {REG_AW{1'b0}})
                    && v_r[k]
                    && (rd_r[k] == id_rs[i*REG_AW +: REG_AW]);
                found = found | m;
                win   = m ? IDX_W'(k) : win;
            end
            sel        = sel_r[win];
            fwd_hit[i] = found;
            haz_s[i]   = found && (sel == 2'b01) && (win < IDX_W'(LOAD_LAT));
            if (found) begin
                case (sel)
                    2'b01:   fwd_data[i*XLEN +: XLEN] = stage_rdata[win*XLEN +: XLEN];
                    2'b10:   fwd_data[i*XLEN +: XLEN] = stage_pcn[win*XLEN +: XLEN];
                    default: fwd_data[i*XLEN +: XLEN] = stage_alu[win*XLEN +: XLEN];
                endcase
            end else begin
                fwd_data[i*XLEN +: XLEN] = rf_data[i*XLEN +: XLEN];
            end
        end
    end

    // An older non-hazard match cannot hide a younger hazard since only the winner is examined.
    assign stall_s   = id_valid & (|haz_s);
    assign stall     = stall_s;
    assign stall_cnt = cnt_r;

    // Tag pipeline: shift on every unfrozen edge; stalled or flushed slots become bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_r[k]  <= {REG_AW{1'b0}};
                sel_r[k] <= 2'b00;
            end
        end else if (!pipe_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_r[k]   <= v_r[k-1];
                rd_r[k]  <= rd_r[k-1];
                sel_r[k] <= sel_r[k-1];
            end
            v_r[0]   <= id_valid & id_regwrite & ~stall_s & ~flush;
            rd_r[0]  <= id_rd;
            sel_r[0] <= id_memtoreg;
        end
    end

    // Saturating stall-cycle counter; frozen cycles are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!pipe_hold && stall_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench for fwd_scoreboard_unit: a reference tag model predicts outputs per cycle,
// expectations are queued at drive time and popped when the outputs are sampled.
module tb_fwd_scoreboard_unit;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [NUM_SRC*XLEN-1:0]   rf_data;
    logic id_regwrite;
    logic [REG_AW-1:0] id_rd;
    logic [1:0] id_memtoreg;
    logic pipe_hold;
    logic flush;
    logic [DEPTH*XLEN-1:0] stage_alu, stage_rdata, stage_pcn;
    logic [NUM_SRC*XLEN-1:0] fwd_data;
    logic [NUM_SRC-1:0] fwd_hit;
    logic stall;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    fwd_scoreboard_unit #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
        .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .rf_data(rf_data), .id_regwrite(id_regwrite),
        .id_rd(id_rd), .id_memtoreg(id_memtoreg), .pipe_hold(pipe_hold), .flush(flush),
        .stage_alu(stage_alu), .stage_rdata(stage_rdata), .stage_pcn(stage_pcn),
        .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
    );

    typedef struct {
        string             tag;
        logic [NUM_SRC-1:0] hit;
        logic [NUM_SRC-1:0] dcare;
        logic [XLEN-1:0]   data [NUM_SRC];
        logic              stall;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    bit              m_v   [DEPTH];
    logic [REG_AW-1:0] m_rd [DEPTH];
    logic [1:0]      m_sel [DEPTH];
    int              m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_stage(input int k, input logic [XLEN-1:0] alu,
                             input logic [XLEN-1:0] rdat, input logic [XLEN-1:0] pcn);
        stage_alu[k*XLEN +: XLEN]   = alu;
        stage_rdata[k*XLEN +: XLEN] = rdat;
        stage_pcn[k*XLEN +: XLEN]   = pcn;
    endtask

    function automatic exp_t build_exp(input string tag);
        exp_t e;
        logic haz_any;
        haz_any = 1'b0;
        e.tag = tag;
        e.hit = '0;
        e.dcare = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_AW-1:0] rs;
            bit found;
            rs = id_rs[i*REG_AW +: REG_AW];
            found = 1'b0;
            e.data[i] = rf_data[i*XLEN +: XLEN];
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && id_rs_used[i] && rs != 0 && m_v[k] && m_rd[k] == rs) begin
                    found = 1'b1;
                    e.hit[i] = 1'b1;
                    if (m_sel[k] == 2'b01) e.data[i] = stage_rdata[k*XLEN +: XLEN];
                    else if (m_sel[k] == 2'b10) e.data[i] = stage_pcn[k*XLEN +: XLEN];
                    else e.data[i] = stage_alu[k*XLEN +: XLEN];
                    if (m_sel[k] == 2'b01 && k < LOAD_LAT) begin
                        e.dcare[i] = 1'b1;
                        haz_any = 1'b1;
                    end
                end
            end
        end
        e.stall = id_valid & haz_any;
        e.cnt = CNT_W'(m_cnt);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check_eq({e.tag, "_stall"}, {63'd0, stall}, {63'd0, e.stall});
        check_eq({e.tag, "_cnt"}, {60'd0, stall_cnt}, {60'd0, e.cnt});
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!e.dcare[i]) begin
                check_eq($sformatf("%s_hit%0d", e.tag, i), {63'd0, fwd_hit[i]}, {63'd0, e.hit[i]});
                check_eq($sformatf("%s_data%0d", e.tag, i),
                         {32'd0, fwd_data[i*XLEN +: XLEN]}, {32'd0, e.data[i]});
            end
        end
    endtask

    task automatic drive(input string tag, input bit valid, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic [1:0] used, input bit rw,
                         input logic [4:0] rd, input logic [1:0] mtr, input bit hold, input bit fl);
        exp_t e;
        @(negedge clk);
        id_valid = valid; id_rs = {rs1, rs0}; id_rs_used = used;
        id_regwrite = rw; id_rd = rd; id_memtoreg = mtr; pipe_hold = hold; flush = fl;
        rf_data = {$urandom, $urandom};
        e = build_exp(tag);
        sb_q.push_back(e);
        #1 compare_out();
        if (!hold) begin
            if (e.stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_sel[k] = m_sel[k-1];
            end
            m_v[0] = valid & rw & !e.stall & !fl;
            m_rd[0] = rd;
            m_sel[0] = mtr;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
        m_cnt = 0;
        sb_q.push_back(build_exp(tag));
        #1 compare_out();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = '0; id_rs_used = '0; rf_data = '0; id_regwrite = 0;
        id_rd = '0; id_memtoreg = '0; pipe_hold = 0; flush = 0;
        stage_alu = '0; stage_rdata = '0; stage_pcn = '0;
        for (int k = 0; k < DEPTH; k++) begin m_v[k] = 0; m_rd[k] = '0; m_sel[k] = '0; end
        m_cnt = 0;
        do_reset("rst0");

        // ALU back-to-back
        drive("add5", 1, 0, 0, 2'b00, 1, 5, 2'b00, 0, 0);
        set_stage(0, 32'h1234, 32'hDEAD0000, 32'h100);
        set_stage(1, 32'h5555, 32'h6666, 32'h7777);
        drive("use5", 1, 5, 0, 2'b01, 0, 0, 2'b00, 0, 0);
        check_eq("use5_direct", {32'd0, fwd_data[31:0]}, 64'h1234);

        // load-use: one stall cycle, then stage-1 load data
        drive("lw7", 1, 0, 0, 2'b00, 1, 7, 2'b01, 0, 0);
        drive("lu7a", 1, 0, 7, 2'b10, 0, 0, 2'b00, 0, 0);
        set_stage(1, 32'h0, 32'hCAFEBABE, 32'h0);
        drive("lu7b", 1, 0, 7, 2'b10, 0, 0, 2'b00, 0, 0);
        check_eq("lu7b_direct", {32'd0, fwd_data[63:32]}, 64'hCAFEBABE);
        check_eq("lu7b_cnt", {60'd0, stall_cnt}, 64'd1);

        // priority and x0
        drive("w3a", 1, 0, 0, 2'b00, 1, 3, 2'b00, 0, 0);
        drive("w3b", 1, 0, 0, 2'b00, 1, 3, 2'b00, 0, 0);
        set_stage(0, 32'h11, 32'h0, 32'h0);
        set_stage(1, 32'h22, 32'h0, 32'h0);
        drive("rd3", 1, 3, 3, 2'b11, 0, 0, 2'b00, 0, 0);
        drive("w0", 1, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0);
        drive("rd0", 1, 0, 0, 2'b11, 0, 0, 2'b00, 0, 0);

        // JAL link value from stage 1
        drive("jal1", 1, 0, 0, 2'b00, 1, 1, 2'b10, 0, 0);
        drive("nop", 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        set_stage(1, 32'hBAD, 32'hBAD2, 32'h400);
        drive("rd1", 1, 0, 1, 2'b10, 0, 0, 2'b00, 0, 0);

        // hold during a load-use stall
        drive("lw9", 1, 0, 0, 2'b00, 1, 9, 2'b01, 0, 0);
        repeat (3) drive("hold9", 1, 9, 0, 2'b01, 0, 0, 2'b00, 1, 0);
        drive("st9", 1, 9, 0, 2'b01, 0, 0, 2'b00, 0, 0);
        set_stage(1, 32'h1, 32'h9999, 32'h2);
        drive("fw9", 1, 9, 0, 2'b01, 0, 0, 2'b00, 0, 0);

        // flush kills a writer; stall with flush inserts a bubble
        drive("fl12", 1, 0, 0, 2'b00, 1, 12, 2'b00, 0, 1);
        drive("rd12a", 1, 12, 0, 2'b01, 0, 0, 2'b00, 0, 0);
        drive("rd12b", 1, 12, 12, 2'b11, 0, 0, 2'b00, 0, 0);
        drive("lw6", 1, 0, 0, 2'b00, 1, 6, 2'b01, 0, 0);
        drive("sf6", 1, 6, 0, 2'b01, 1, 6, 2'b00, 0, 1);
        drive("af6", 1, 6, 0, 2'b01, 0, 0, 2'b00, 0, 0);

        // reset in the middle of a stall
        drive("lw4", 1, 0, 0, 2'b00, 1, 4, 2'b01, 0, 0);
        drive("lu4", 1, 4, 0, 2'b01, 0, 0, 2'b00, 0, 0);
        do_reset("rst_mid");

        // counter saturation
        for (int n = 0; n < 20; n++) begin
            drive("sat_lw", 1, 0, 0, 2'b00, 1, 8, 2'b01, 0, 0);
            drive("sat_use", 1, 8, 0, 2'b01, 0, 0, 2'b00, 0, 0);
        end
        drive("sat_end", 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        check_eq("sat_direct", {60'd0, stall_cnt}, 64'd15);

        // random traffic
        do_reset("rst_rand");
        for (int n = 0; n < 80; n++) begin
            for (int k = 0; k < DEPTH; k++) set_stage(k, $urandom, $urandom, $urandom);
            drive("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 2'($urandom), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Parametrised next-generation operand forwarding unit for the pipelined CPU.
- Keeps an internal tag pipeline recording the destination register and write-back source of every in-flight instruction (stage 0 = EX, stage 1 = MEM, ...).
- For each of NUM_SRC source operands in ID, it picks the youngest matching in-flight result or the register-file value.
- It raises a load-use stall when a required load result is not yet available, and counts stall cycles.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands forwarded in parallel.
- DEPTH, 2, number of tracked in-flight stages (>=2).
- LOAD_LAT, 1, first stage index at which load data is valid (1..DEPTH-1).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  NUM_SRC*REG_AW  source register addresses; operand i in slice i.
- id_rs_used  in  NUM_SRC  operand i is actually read.
- rf_data  in  NUM_SRC*XLEN  register-file read data per operand.
- id_regwrite  in  1  ID instruction writes a register.
- id_rd  in  REG_AW  ID destination register.
- id_memtoreg  in  2  ID write-back source: 00 ALU, 01 load, 10 PC_next, 11 reserved (treated as ALU).
- pipe_hold  in  1  whole pipeline frozen (e.g. memory wait).
- flush  in  1  kill the instruction leaving ID this cycle.
- stage_alu  in  DEPTH*XLEN  ALU result held in stage k (slice k).
- stage_rdata  in  DEPTH*XLEN  load data in stage k; valid only for k>=LOAD_LAT.
- stage_pcn  in  DEPTH*XLEN  PC_next held in stage k.
- fwd_data  out  NUM_SRC*XLEN  operand values for EX.
- fwd_hit  out  NUM_SRC  operand i taken from the pipeline, not rf_data.
- stall  out  1  hold PC/IF/ID and insert a bubble.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State:
  - DEPTH entries {v, rd, sel}.
  - stall_cnt register.
  - All other outputs are combinational from state and inputs.
- Reset (async, rst_n=0):
  - All entry v=0 and stall_cnt=0, effective immediately.
  - Hence stall=0, fwd_hit=0, fwd_data=rf_data.
  - Reset mid-operation discards all in-flight tags.
- Entry k matches operand i when:
  - id_rs_used[i]=1,
  - id_rs[i]!=0,
  - entry[k].v=1,
  - entry[k].rd=id_rs[i].
- Register 0 never matches.
- Priority: the lowest k (youngest) match wins; older matches are ignored.
- Forward value for the winning entry k:
  - sel=01 -> stage_rdata[k]
  - sel=10 -> stage_pcn[k]
  - else -> stage_alu[k]
- No match -> rf_data[i], fwd_hit[i]=0.
- Load-use hazard for operand i: the winning entry has sel=01 and k<LOAD_LAT.
- stall = id_valid AND (any operand hazard).
  - An older non-hazard match does not mask a younger hazard.
  - During a hazard, fwd_data[i] is don't-care.
- Tag pipeline update on each rising edge when pipe_hold=0:
  - entry[k] <= entry[k-1] for k=1..DEPTH-1.
  - entry[0].v <= id_valid & id_regwrite & !stall & !flush.
  - entry[0].rd <= id_rd and entry[0].sel <= id_memtoreg, captured regardless of v.
- The oldest entry drops off; its result is assumed written to the register file.
- pipe_hold=1:
  - No shift and no capture; entries are frozen.
  - stall and fwd_data are still evaluated combinationally.
- Simultaneous stall and flush: bubble inserted (v=0).
- Stall timing with LOAD_LAT=1: a dependent instruction immediately after a load stalls exactly 1 cycle, then forwards from stage 1 stage_rdata.
- stall_cnt:
  - +1 on each edge where stall=1 and pipe_hold=0.
  - Saturates at 2^CNT_W-1; no wrap.

Test Plan:
- ALU back-to-back: issue add x5 (sel 00), next ID rs0=x5, stage_alu[0]=0x1234 -> fwd_hit[0]=1, fwd_data[0]=0x1234, stall=0.
- Load-use: issue lw x7 (sel 01), next ID rs1=x7 -> stall=1 for exactly 1 cycle, stall_cnt=1; next cycle fwd_data[1]=stage_rdata[1]=0xCAFEBABE, stall=0.
- Priority and x0: stage 0 and stage 1 both write x3 (alu 0x11, 0x22) -> fwd_data=0x11; rs=x0 with a stage-0 entry rd=x0 -> fwd_hit=0, fwd_data=rf_data.
- JAL link: stage 1 entry sel=10, rd=x1, stage_pcn[1]=0x400 -> operand reading x1 gets 0x400.
- Hold and flush: pipe_hold=1 for 3 cycles during a load-use stall -> entries frozen, stall_cnt unchanged; flush=1 with valid ID writer -> entry[0].v=0, no later forwarding of that rd.
- Reset and saturation: deassert rst_n mid-stall -> stall=0, fwd_hit=0 at once; with CNT_W=4, force 20 stall cycles -> stall_cnt=15.
